// File: rtl/bp_cacc_lce_flit_serializer.sv
// LCE message to wormhole flit serializer.
// Holds one message and emits a header flit followed by 0..max_payload_flits_p
// payload flits on a ready-and link. A new message may be accepted in the same
// cycle the last flit of the current one is taken, so streams have no bubbles.
module bp_cacc_lce_flit_serializer #(
  parameter int flit_width_p        = 64,
  parameter int cord_width_p        = 7,
  parameter int len_width_p         = 4,
  parameter int max_payload_flits_p = 8,
  localparam int hdr_width_lp       = flit_width_p - cord_width_p - len_width_p
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic [cord_width_p-1:0]                     msg_dst_cord_i,
  input  logic [hdr_width_lp-1:0]                     msg_hdr_i,
  input  logic [max_payload_flits_p*flit_width_p-1:0] msg_payload_i,
  input  logic [len_width_p-1:0]                      msg_payload_flits_i,
  input  logic                                        msg_v_i,
  output logic                                        msg_ready_and_o,
  output logic [flit_width_p-1:0]                     link_data_o,
  output logic                                        link_v_o,
  input  logic                                        link_ready_and_i,
  output logic                                        oversize_o
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [len_width_p-1:0] MaxLen = len_width_p'(max_payload_flits_p);

  state_e                                           state_q, state_d;
  logic [flit_width_p-1:0]                          hdr_flit_q, hdr_flit_d;
  logic [max_payload_flits_p-1:0][flit_width_p-1:0] payload_q, payload_d;
  logic [len_width_p-1:0]                           len_q, len_d;
  logic [len_width_p-1:0]                           cnt_q, cnt_d;
  logic                                             oversize_q, oversize_d;

  logic                   last_flit;
  logic                   accept;
  logic                   oversize_req;
  logic [len_width_p-1:0] len_clamped;

  // Handshake decode: completion of the current message frees the buffer.
  // Ready is forced low while reset is asserted, independent of the clock.
  always_comb begin
    last_flit       = (state_q == SEND) && (cnt_q == len_q) && link_ready_and_i;
    msg_ready_and_o = reset_n_i && ((state_q == IDLE) || last_flit);
    accept          = msg_v_i && msg_ready_and_o;
    oversize_req    = (msg_payload_flits_i > MaxLen);
    len_clamped     = oversize_req ? MaxLen : msg_payload_flits_i;
  end

  // State register plus datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      hdr_flit_q <= '0;
      payload_q  <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      oversize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_flit_q <= hdr_flit_d;
      payload_q  <= payload_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      oversize_q <= oversize_d;
    end
  end

  // Next state: leave SEND only when the last flit goes and nothing replaces it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_flit && !msg_v_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on accept, otherwise advance on each taken flit.
  always_comb begin
    hdr_flit_d = hdr_flit_q;
    payload_d  = payload_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    oversize_d = oversize_q;
    if (accept) begin
      hdr_flit_d = {msg_hdr_i, len_clamped, msg_dst_cord_i};
      payload_d  = msg_payload_i;
      len_d      = len_clamped;
      cnt_d      = '0;
      oversize_d = oversize_q | oversize_req;
    end else if ((state_q == SEND) && link_ready_and_i && (cnt_q < len_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs: header at count 0, payload flit (cnt-1) afterwards.
  always_comb begin
    link_v_o    = (state_q == SEND);
    oversize_o  = oversize_q;
    link_data_o = hdr_flit_q;
    for (int k = 0; k < max_payload_flits_p; k++) begin
      if (cnt_q == len_width_p'(k + 1)) link_data_o = payload_q[k];
    end
  end

endmodule

// File: tb/tb_bp_cacc_lce_flit_serializer.sv
// Directed bench for the LCE flit serializer: table of whole messages plus
// hand-written back-pressure, back-to-back and mid-message reset sequences.
module tb_bp_cacc_lce_flit_serializer;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [6:0]   msg_dst_cord_i;
  logic [52:0]  msg_hdr_i;
  logic [511:0] msg_payload_i;
  logic [3:0]   msg_payload_flits_i;
  logic         msg_v_i;
  logic         msg_ready_and_o;
  logic [63:0]  link_data_o;
  logic         link_v_o;
  logic         link_ready_and_i;
  logic         oversize_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_cacc_lce_flit_serializer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .msg_dst_cord_i(msg_dst_cord_i), .msg_hdr_i(msg_hdr_i),
    .msg_payload_i(msg_payload_i), .msg_payload_flits_i(msg_payload_flits_i),
    .msg_v_i(msg_v_i), .msg_ready_and_o(msg_ready_and_o),
    .link_data_o(link_data_o), .link_v_o(link_v_o),
    .link_ready_and_i(link_ready_and_i), .oversize_o(oversize_o)
  );

  typedef struct {
    logic [6:0]  cord;
    logic [52:0] hdr;
    logic [3:0]  nflits;
    logic [63:0] base;
    logic [3:0]  exp_len;
    logic        exp_ovs;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_flit(input vec_t v, input int i);
    if (i == 0) return {v.hdr, v.exp_len, v.cord};
    return v.base + 64'(i - 1);
  endfunction

  task automatic drive_msg(input vec_t v, input logic valid);
    msg_dst_cord_i      = v.cord;
    msg_hdr_i           = v.hdr;
    msg_payload_flits_i = v.nflits;
    for (int k = 0; k < 8; k++) msg_payload_i[k*64 +: 64] = v.base + 64'(k);
    msg_v_i = valid;
  endtask

  // Send one message from IDLE and collect its flits; bp=1 randomizes link ready.
  task automatic run_msg(input vec_t v, input bit bp);
    int          got;
    int          cyc;
    bit          stalled;
    logic [63:0] prev;
    logic        exp_rdy;
    got = 0; cyc = 0; stalled = 0; prev = '0;
    @(negedge clk_i);
    drive_msg(v, 1'b1);
    link_ready_and_i = 1'b1;
    #1;
    chk("idle_ready", msg_ready_and_o, 1'b1);
    chk("idle_link_v", link_v_o, 1'b0);
    @(negedge clk_i);
    msg_v_i = 1'b0;
    while (got < int'(v.exp_len) + 1 && cyc < 200) begin
      link_ready_and_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("send_link_v", link_v_o, 1'b1);
      if (stalled) chk("stall_hold", link_data_o, prev);
      exp_rdy = link_ready_and_i && (got == int'(v.exp_len));
      chk("send_ready", msg_ready_and_o, exp_rdy);
      if (link_ready_and_i) begin
        chk("flit_data", link_data_o, exp_flit(v, got));
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      prev = link_data_o;
      cyc++;
      @(negedge clk_i);
    end
    chk("msg_done_in_budget", 64'(cyc < 200), 64'd1);
    if (!bp) chk("link_cycles", 64'(cyc), 64'(int'(v.exp_len) + 1));
    link_ready_and_i = 1'b1;
    #1;
    chk("after_idle_link_v", link_v_o, 1'b0);
    chk("after_idle_ready", msg_ready_and_o, 1'b1);
    chk("oversize", oversize_o, v.exp_ovs);
  endtask

  initial begin
    vec_t m[3];
    vec_t r;
    int   j;
    //          cord   hdr                  nflits base        len  ovs
    vecs[0] = '{7'h05, 53'h1ABC,            4'd0,  64'h0,      4'd0, 1'b0};
    vecs[1] = '{7'h2A, 53'h1F_0000_1234,    4'd8,  64'hA000,   4'd8, 1'b0};
    vecs[2] = '{7'h11, 53'h3,               4'd3,  64'hB000,   4'd3, 1'b0};
    vecs[3] = '{7'h7F, 53'h0FEED,           4'd12, 64'hC000,   4'd8, 1'b1};
    vecs[4] = '{7'h01, 53'h42,              4'd1,  64'hD000,   4'd1, 1'b1};

    reset_n_i = 1'b0;
    msg_v_i = 1'b0; link_ready_and_i = 1'b1;
    msg_dst_cord_i = '0; msg_hdr_i = '0; msg_payload_i = '0; msg_payload_flits_i = '0;
    #1;
    chk("rst_ready", msg_ready_and_o, 1'b0);
    chk("rst_link_v", link_v_o, 1'b0);
    chk("rst_oversize", oversize_o, 1'b0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    // Literal header for the zero-payload case: hdr<<11 | 0<<7 | 5.
    chk("zero_hdr_literal", exp_flit(vecs[0], 0), 64'h0000_0000_00D5_E005);

    for (int i = 0; i < 5; i++) run_msg(vecs[i], 1'b0);

    // Back pressure on a 3-flit message.
    r = '{7'h22, 53'h777, 4'd3, 64'hE000, 4'd3, 1'b1};
    run_msg(r, 1'b1);

    // Back-to-back: three 2-payload messages, no gap between them.
    m[0] = '{7'h03, 53'h100, 4'd2, 64'h1000, 4'd2, 1'b1};
    m[1] = '{7'h04, 53'h200, 4'd2, 64'h2000, 4'd2, 1'b1};
    m[2] = '{7'h06, 53'h300, 4'd2, 64'h3000, 4'd2, 1'b1};
    @(negedge clk_i);
    drive_msg(m[0], 1'b1);
    link_ready_and_i = 1'b1;
    for (j = 0; j < 9; j++) begin
      @(negedge clk_i);
      if (j < 6) drive_msg(m[j/3 + 1], 1'b1);
      else msg_v_i = 1'b0;
      #1;
      chk("b2b_link_v", link_v_o, 1'b1);
      chk("b2b_data", link_data_o, exp_flit(m[j/3], j%3));
      chk("b2b_ready", msg_ready_and_o, (j%3) == 2);
    end
    @(negedge clk_i);
    #1;
    chk("b2b_end_link_v", link_v_o, 1'b0);

    // Reset mid-message, asserted between clock edges on the 2nd payload flit.
    r = '{7'h09, 53'h999, 4'd3, 64'hF000, 4'd3, 1'b1};
    @(negedge clk_i);
    drive_msg(r, 1'b1);
    @(negedge clk_i);
    msg_v_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("pre_rst_data", link_data_o, 64'hF001);
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_link_v", link_v_o, 1'b0);
    chk("mid_rst_ready", msg_ready_and_o, 1'b0);
    chk("mid_rst_oversize", oversize_o, 1'b0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    chk("post_rst_ready", msg_ready_and_o, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      chk("post_rst_no_resume", link_v_o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
